hmax_accumulator: RTL

HMAX_ACCUMULATOR -- requirements
Module: hmax_accumulator

---
 rtl/maxpool_pkg.sv | 22 ++
 rtl/vec_max2.sv | 19 +
 rtl/hmax_accumulator.sv | 106 ++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pooling pipeline (horizontal and vertical stages).
// Holds default geometry, the filter-size width helper and the window FSM encoding.
package maxpool_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int SA_LENGTH_DEF       = 256;
  localparam int MAX_FILTER_SIZE_DEF = 7;

  // Window height field must be able to represent MAX_FILTER_SIZE itself.
  function automatic int fs_width(input int max_fs);
    return $clog2(max_fs + 1);
  endfunction

  localparam int FS_W_DEF = fs_width(MAX_FILTER_SIZE_DEF);
  typedef logic [FS_W_DEF-1:0] fs_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/vec_max2.sv
// Element-wise signed max of two row vectors; purely combinational, no backpressure.
module vec_max2
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SA_LENGTH  = SA_LENGTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a [SA_LENGTH],
  input  logic signed [DATA_WIDTH-1:0] b [SA_LENGTH],
  output logic signed [DATA_WIDTH-1:0] y [SA_LENGTH]
);

  always_comb begin
    for (int j = 0; j < SA_LENGTH; j++) begin
      y[j] = (a[j] > b[j]) ? a[j] : b[j];
    end
  end

endmodule

// File: rtl/hmax_accumulator.sv
// Running element-wise max over a window of rows; result registered one cycle after the closing row.
// Single-entry output buffer: in_ready = !out_valid || out_ready, so a pop and a new result share an edge.
module hmax_accumulator
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int SA_LENGTH       = SA_LENGTH_DEF,
  parameter int MAX_FILTER_SIZE = MAX_FILTER_SIZE_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [fs_width(MAX_FILTER_SIZE)-1:0]   cfg_filter_size,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [DATA_WIDTH-1:0]           in_data [SA_LENGTH],
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [DATA_WIDTH-1:0]           out_data [SA_LENGTH],
  output logic                                   out_last
);

  localparam int FS_W = fs_width(MAX_FILTER_SIZE);
  localparam logic [FS_W-1:0] FS_ONE = FS_W'(1);
  localparam logic [FS_W-1:0] FS_MAX = FS_W'(MAX_FILTER_SIZE);

  state_t                        state;
  logic [FS_W-1:0]               cnt;
  logic [FS_W-1:0]               fs_q;
  logic [FS_W-1:0]               fs_cfg;
  logic [FS_W-1:0]               fs_now;
  int                            cfg_int;
  logic                          first;
  logic                          complete;
  logic                          push;
  logic                          pop;
  logic signed [DATA_WIDTH-1:0]  acc     [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0]  max_vec [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0]  row_val [SA_LENGTH];

  vec_max2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .SA_LENGTH  (SA_LENGTH)
  ) u_vec_max2 (
    .a (acc),
    .b (in_data),
    .y (max_vec)
  );

  // Window size is sampled only on the first row of a window; clamp to 1..MAX_FILTER_SIZE.
  always_comb begin
    cfg_int = int'(cfg_filter_size);
    fs_cfg  = cfg_filter_size;
    if (cfg_int == 0) begin
      fs_cfg = FS_ONE;
    end else if (cfg_int > MAX_FILTER_SIZE) begin
      fs_cfg = FS_MAX;
    end
  end

  always_comb begin
    first    = (state == ST_IDLE);
    fs_now   = first ? fs_cfg : fs_q;
    in_ready = !out_valid || out_ready;
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    complete = in_last || ((cnt + FS_ONE) == fs_now);
    for (int j = 0; j < SA_LENGTH; j++) begin
      row_val[j] = first ? in_data[j] : max_vec[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      fs_q      <= FS_ONE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      acc       <= '{default: '0};
      out_data  <= '{default: '0};
    end else begin
      if (pop) begin
        out_valid <= 1'b0;
      end
      if (push) begin
        if (first) begin
          fs_q <= fs_cfg;
        end
        // A completing push overrides the pop above and keeps the buffer full.
        if (complete) begin
          out_data  <= row_val;
          out_last  <= in_last;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
          cnt       <= '0;
        end else begin
          acc   <= row_val;
          cnt   <= cnt + FS_ONE;
          state <= ST_ACCUM;
        end
      end
    end
  end

endmodule
